uart_baud_gen_frac: RTL
=======================

# uart_baud_gen_frac

Fractional, runtime-programmable baud generator for the UART datapath. It produces an oversampling tick (`os_tick`), a bit-rate tick (`bit_tick`) and a mid-bit sample tick (`mid_tick`) from a single system clock. The divisor has an integer part and a fractional part, so standard baud rates are hit with low average error. RX uses `phase_rst` to realign the bit phase on a start-bit edge; TX uses `bit_tick` directly.

## Interface
Parameters:
- `CLK_FREQ`, default 32000000: system clock in Hz; used only for the reset divisor.
- `BAUD_RATE`, default 115200: reset baud rate in bps.
- `OVERSAMPLE`, default 16: `os_tick`s per bit. Must be even and ≥ 4.
- `INT_W`, default 16: width of the integer divisor part.
- `FRAC_W`, default 4: width of the fractional divisor part, in units of 1/2^FRAC_W clock.

Ports:
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: run enable.
- `phase_rst`, in, 1: synchronous realignment of the tick phase.
- `div_load`, in, 1: one-cycle strobe that writes `div_int` and `div_frac`.
- `div_int`, in, `INT_W`: integer clocks per `os_tick`.
- `div_frac`, in, `FRAC_W`: fractional clocks per `os_tick`.
- `os_tick`, out, 1: one-cycle pulse per oversample period.
- `mid_tick`, out, 1: one-cycle pulse, coincident with the `os_tick` that brings `os_phase` to `OVERSAMPLE/2`.
- `bit_tick`, out, 1: one-cycle pulse, coincident with the `os_tick` that wraps `os_phase` to 0.
- `os_phase`, out, clog2(`OVERSAMPLE`): current oversample index.
- `cfg_err`, out, 1: sticky flag for a rejected divisor load.

## Operation
Reset divisor:
- D = round(CLK_FREQ·2^FRAC_W / (BAUD_RATE·OVERSAMPLE)).
- Active `div_int` = D >> FRAC_W; active `div_frac` = D mod 2^FRAC_W.
- With the defaults, D = 278, giving `div_int` = 17 and `div_frac` = 6 (17.375 clocks per `os_tick`).

Reset values:
- `os_tick`, `mid_tick`, `bit_tick`, `cfg_err`: 0.
- `os_phase`: 0.
- Fraction accumulator `acc` (`FRAC_W` bits): 0.
- Down-counter `cnt` (`INT_W` bits): 0.
- State: IDLE.

Interval period:
- Each interval start computes {c, acc} ← acc + `div_frac`.
- Interval period P = `div_int` + c clocks.
- `cnt` loads P−1. Because P ≤ 2^INT_W, `cnt` always fits in `INT_W` bits.

State machine:
- IDLE:
  - `cnt`, `acc` and `os_phase` held at 0; all ticks 0.
  - On an edge with `en`=1 (and `phase_rst` ignored): start the first interval and go to RUN.
- RUN, normal counting:
  - If `cnt` ≠ 0: decrement `cnt`.
  - If `cnt` = 0: register `os_tick`=1, start the next interval, and increment `os_phase` modulo `OVERSAMPLE`.
  - `mid_tick`=1 on that edge if the old `os_phase` = `OVERSAMPLE/2`−1.
  - `bit_tick`=1 on that edge if the old `os_phase` = `OVERSAMPLE`−1.
- RUN with `en`=0 (highest priority): go to IDLE and clear counters as in reset. `cfg_err` and the active divisor are kept.
- RUN with `phase_rst`=1 and `en`=1:
  - Set `acc`=0 and `os_phase`=0.
  - Start a fresh interval from `acc`=0.
  - Force all ticks to 0 that cycle, even if `cnt` was 0.

Divisor load:
- On `div_load`, if `div_int` ≥ 2: write the active divisor and clear `cfg_err`.
- Otherwise: leave the active divisor unchanged and set `cfg_err`=1.
- The interval in flight is never altered. The new divisor takes effect at the next interval start, including one on the same edge as the load.

## Timing
- All outputs are registered; no combinational input-to-output path.
- First `os_tick` after enable:
  - Edge 0 is the first edge that samples `en`=1 in IDLE.
  - `os_tick` goes high after edge P₁ and lasts one cycle.
- Consecutive `os_tick`s are spaced exactly by the current interval P, with no dead cycle.
- Over 2^FRAC_W consecutive intervals, the total is exactly 2^FRAC_W·`div_int` + `div_frac` clocks.
- After `phase_rst`, the first `mid_tick` arrives `OVERSAMPLE/2` intervals later, and `bit_tick` arrives `OVERSAMPLE` intervals later.
- Asynchronous reset mid-interval clears all state immediately. Ticks restart only on a subsequent `en`.

## Test plan
- **Default rate:**
  - Stimulus: reset, then `en`=1.
  - First six `os_tick` gaps are 17, 17, 18, 17, 17, 18 clocks.
  - 16 `os_tick`s span exactly 278 clocks, with one `bit_tick` and one `mid_tick`.
- **Minimum divisor:**
  - Stimulus: load `div_int`=2, `div_frac`=0.
  - `os_tick` every 2 clocks; `bit_tick` every 32 clocks.
- **Illegal load:**
  - Stimulus: `div_load` with `div_int`=1.
  - `cfg_err`=1 and the period is unchanged.
  - A following load of 4/0 clears `cfg_err`, and the gap becomes 4 clocks.
- **Mid-interval load:**
  - Stimulus: from 17/6, load 10/0 while `cnt`=5.
  - The current interval still completes; all subsequent gaps are 10 clocks.
- **Realignment:**
  - Stimulus: `phase_rst` pulse with `os_phase`=11.
  - No tick that cycle; `os_phase`=0.
  - `mid_tick` arrives after exactly 8 `os_tick`s.
- **Disable and reset:**
  - Stimulus: drop `en` mid-interval, then re-enable.
  - Ticks stop and `os_phase`=0; the first tick after re-enable follows the first-tick rule.
  - Stimulus: assert `rst_n` low mid-interval.
  - All outputs go to 0 immediately and the divisor reverts to 17/6.

Source files
------------

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud generator: produces oversample, mid-bit and bit-rate ticks
// from an integer+fractional divisor.
// The fractional part accumulates per interval. Its carry stretches an interval by one clock.
module uart_baud_gen_frac #(
  parameter int unsigned CLK_FREQ   = 32000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned INT_W      = 16,
  parameter int unsigned FRAC_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          phase_rst,
  input  logic                          div_load,
  input  logic [INT_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  output logic                          os_tick,
  output logic                          mid_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
  output logic                          cfg_err
);

  localparam int unsigned PH_W = $clog2(OVERSAMPLE);

  // Reset divisor: round(CLK_FREQ * 2^FRAC_W / (BAUD_RATE * OVERSAMPLE)).
  localparam longint unsigned RstNum  = 64'(CLK_FREQ) << FRAC_W;
  localparam longint unsigned RstDen  = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
  localparam longint unsigned RstD    = (64'd2 * RstNum + RstDen) / (64'd2 * RstDen);
  localparam longint unsigned RstInt  = RstD >> FRAC_W;
  localparam longint unsigned RstFrac = RstD & ((64'd1 << FRAC_W) - 64'd1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [INT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              os_tick_q, os_tick_d;
  logic              mid_tick_q, mid_tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic [INT_W-1:0]  div_int_q, div_int_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d;
  logic              cfg_err_q, cfg_err_d;

  logic              load_ok;
  logic [INT_W-1:0]  int_eff;
  logic [FRAC_W-1:0] frac_eff;
  logic [FRAC_W-1:0] acc_base;
  logic [FRAC_W:0]   sum;
  logic [INT_W-1:0]  per_m1;
  logic [PH_W-1:0]   phase_inc;

  // Divisor seen by an interval starting this edge; a same-edge load wins.
  always_comb begin
    load_ok  = div_load && (div_int >= INT_W'(2));
    int_eff  = load_ok ? div_int  : div_int_q;
    frac_eff = load_ok ? div_frac : div_frac_q;
    // Realignment and the first interval both start from a zero accumulator.
    acc_base = (state_q == StRun && !phase_rst) ? acc_q : '0;
    sum      = {1'b0, acc_base} + {1'b0, frac_eff};
    per_m1   = int_eff + INT_W'(sum[FRAC_W]) - INT_W'(1);
    phase_inc = (phase_q == PH_W'(OVERSAMPLE - 1)) ? '0 : phase_q + PH_W'(1);
  end

  // Divisor register and sticky configuration error.
  always_comb begin
    div_int_d  = div_int_q;
    div_frac_d = div_frac_q;
    cfg_err_d  = cfg_err_q;
    if (div_load) begin
      cfg_err_d = !load_ok;
      if (load_ok) begin
        div_int_d  = div_int;
        div_frac_d = div_frac;
      end
    end
  end

  // Interval counter, accumulator, phase and tick generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    phase_d    = phase_q;
    os_tick_d  = 1'b0;
    mid_tick_d = 1'b0;
    bit_tick_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (en) begin
          cnt_d   = per_m1;
          acc_d   = sum[FRAC_W-1:0];
          state_d = StRun;
        end
      end
      StRun: begin
        if (!en) begin
          state_d = StIdle;
          cnt_d   = '0;
          acc_d   = '0;
          phase_d = '0;
        end else if (phase_rst) begin
          cnt_d   = per_m1;
          acc_d   = sum[FRAC_W-1:0];
          phase_d = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - INT_W'(1);
        end else begin
          os_tick_d  = 1'b1;
          mid_tick_d = (phase_q == PH_W'(OVERSAMPLE / 2 - 1));
          bit_tick_d = (phase_q == PH_W'(OVERSAMPLE - 1));
          cnt_d      = per_m1;
          acc_d      = sum[FRAC_W-1:0];
          phase_d    = phase_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      phase_q    <= '0;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
      div_int_q  <= RstInt[INT_W-1:0];
      div_frac_q <= RstFrac[FRAC_W-1:0];
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      os_tick_q  <= os_tick_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
      div_int_q  <= div_int_d;
      div_frac_q <= div_frac_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign mid_tick = mid_tick_q;
  assign bit_tick = bit_tick_q;
  assign os_phase = phase_q;
  assign cfg_err  = cfg_err_q;

endmodule
